// File: rtl/cluster_multi_clock_gate_if.sv
// Control/status bundle between the cluster control unit and the clock-gating controller.
// The master side drives permissions, busy lines and wake sources; the slave side returns isolation, gated status and clocks.
interface cluster_multi_clock_gate_if #(
   parameter int NB_DOMAINS = 2,
   parameter int NB_BUSY    = 4,
   parameter int IDLE_CNT_W = 4
);
   logic [NB_DOMAINS-1:0]         cg_en_i;
   logic [IDLE_CNT_W-1:0]         idle_thr_i;
   logic [NB_DOMAINS*NB_BUSY-1:0] busy_i;
   logic [NB_DOMAINS-1:0]         events_i;
   logic [NB_DOMAINS-1:0]         incoming_req_i;
   logic [NB_DOMAINS-1:0]         isolate_o;
   logic [NB_DOMAINS-1:0]         gated_o;
   logic [NB_DOMAINS-1:0]         domain_clk_o;

   modport master (
      output cg_en_i, idle_thr_i, busy_i, events_i, incoming_req_i,
      input  isolate_o, gated_o, domain_clk_o
   );

   modport slave (
      input  cg_en_i, idle_thr_i, busy_i, events_i, incoming_req_i,
      output isolate_o, gated_o, domain_clk_o
   );
endinterface

// File: rtl/cluster_multi_clock_gate.sv
// Per-domain idle-driven clock gating with isolation lead/lag windows around the gated period.
// Clock off thr+ISO_CYCLES cycles after idle onset; back on 1 cycle after wake (+2 for synchronised events).

module cluster_clkgating (
   input  logic i_clk,
   input  logic i_test_mode,
   input  logic i_enable,
   output logic o_gated_clk
);
   logic r_en_latch;

   // Enable captured while the clock is low so the gated clock never glitches.
   always_latch begin
      if (!i_clk) r_en_latch <= i_enable | i_test_mode;
   end

   assign o_gated_clk = i_clk & r_en_latch;
endmodule

module cluster_multi_clock_gate #(
   parameter int NB_DOMAINS  = 2,
   parameter int NB_BUSY     = 4,
   parameter int IDLE_CNT_W  = 4,
   parameter int ISO_CYCLES  = 2,
   parameter int SYNC_EVENTS = 0
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      test_mode_i,
   cluster_multi_clock_gate_if.slave cg_if
);
   localparam int ISO_W = $clog2(ISO_CYCLES + 1);
   localparam int THR_W = IDLE_CNT_W + 1;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_ISO_IN  = 2'd1,
      ST_GATED   = 2'd2,
      ST_ISO_OUT = 2'd3
   } state_t;

   logic                  r_rst_dly;
   logic [THR_W-1:0]      w_thr;
   logic [NB_DOMAINS-1:0] w_ev;
   logic [NB_DOMAINS-1:0] w_iso;
   logic [NB_DOMAINS-1:0] w_gated;
   logic [NB_DOMAINS-1:0] w_dclk;

   // Keeps every domain isolated until the first clock edge after reset release.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) r_rst_dly <= 1'b0;
      else         r_rst_dly <= 1'b1;
   end

   assign w_thr = (cg_if.idle_thr_i == '0) ? THR_W'(1) : THR_W'(cg_if.idle_thr_i);

   if (SYNC_EVENTS != 0) begin : g_sync
      logic [NB_DOMAINS-1:0] r_ev_s1;
      logic [NB_DOMAINS-1:0] r_ev_s2;

      always_ff @(posedge clk_i or negedge rstn_i) begin
         if (!rstn_i) begin
            r_ev_s1 <= '0;
            r_ev_s2 <= '0;
         end else begin
            r_ev_s1 <= cg_if.events_i;
            r_ev_s2 <= r_ev_s1;
         end
      end

      assign w_ev = r_ev_s2;
   end else begin : g_nosync
      assign w_ev = cg_if.events_i;
   end

   for (genvar d = 0; d < NB_DOMAINS; d++) begin : g_dom
      state_t                r_state;
      logic [IDLE_CNT_W-1:0] r_idle_cnt;
      logic [ISO_W-1:0]      r_iso_cnt;
      logic                  r_en;
      logic                  r_iso;
      logic                  r_gated;
      logic                  w_wake;
      logic [THR_W-1:0]      w_idle_nxt;
      logic                  w_iso_last;
      logic                  w_en;

      assign w_wake     = (|cg_if.busy_i[d*NB_BUSY +: NB_BUSY]) | cg_if.incoming_req_i[d]
                        | w_ev[d] | ~cg_if.cg_en_i[d];
      assign w_idle_nxt = THR_W'(r_idle_cnt) + THR_W'(1);
      assign w_iso_last = (32'(r_iso_cnt) + 32'd1) >= 32'(ISO_CYCLES);

      // Wake has priority over idle progress in every state except the fixed ISO_OUT window.
      always_ff @(posedge clk_i or negedge rstn_i) begin
         if (!rstn_i) begin
            r_state    <= ST_RUN;
            r_idle_cnt <= '0;
            r_iso_cnt  <= '0;
            r_en       <= 1'b1;
            r_iso      <= 1'b0;
            r_gated    <= 1'b0;
         end else begin
            case (r_state)
               ST_RUN: begin
                  if (w_wake) begin
                     r_idle_cnt <= '0;
                  end else if (w_idle_nxt >= w_thr) begin
                     r_state    <= ST_ISO_IN;
                     r_idle_cnt <= w_thr[IDLE_CNT_W-1:0];
                     r_iso_cnt  <= '0;
                     r_iso      <= 1'b1;
                  end else begin
                     r_idle_cnt <= w_idle_nxt[IDLE_CNT_W-1:0];
                  end
               end
               ST_ISO_IN: begin
                  if (w_wake) begin
                     r_state   <= ST_ISO_OUT;
                     r_iso_cnt <= '0;
                  end else if (w_iso_last) begin
                     r_state   <= ST_GATED;
                     r_iso_cnt <= '0;
                     r_en      <= 1'b0;
                     r_gated   <= 1'b1;
                  end else begin
                     r_iso_cnt <= r_iso_cnt + ISO_W'(1);
                  end
               end
               ST_GATED: begin
                  if (w_wake) begin
                     r_state   <= ST_ISO_OUT;
                     r_iso_cnt <= '0;
                     r_en      <= 1'b1;
                     r_gated   <= 1'b0;
                  end
               end
               ST_ISO_OUT: begin
                  if (w_iso_last) begin
                     r_state    <= ST_RUN;
                     r_iso_cnt  <= '0;
                     r_idle_cnt <= '0;
                     r_iso      <= 1'b0;
                  end else begin
                     r_iso_cnt <= r_iso_cnt + ISO_W'(1);
                  end
               end
               default: begin
                  r_state    <= ST_RUN;
                  r_idle_cnt <= '0;
                  r_iso_cnt  <= '0;
                  r_en       <= 1'b1;
                  r_iso      <= 1'b0;
                  r_gated    <= 1'b0;
               end
            endcase
         end
      end

      assign w_en       = r_en & rstn_i;
      assign w_iso[d]   = r_iso;
      assign w_gated[d] = r_gated;

      cluster_clkgating u_cg (
         .i_clk       (clk_i),
         .i_test_mode (test_mode_i),
         .i_enable    (w_en),
         .o_gated_clk (w_dclk[d])
      );
   end

   assign cg_if.isolate_o    = w_iso | ~{NB_DOMAINS{r_rst_dly}};
   assign cg_if.gated_o      = w_gated;
   assign cg_if.domain_clk_o = w_dclk;
endmodule

// File: tb/tb_cluster_multi_clock_gate.sv
// Bench: directed vector table plus randomized traffic against a countdown-based reference model.
module tb_cluster_multi_clock_gate;
   localparam int ND  = 2;
   localparam int NB  = 4;
   localparam int CW  = 4;
   localparam int ISO = 2;

   localparam int M_RUN   = 0;
   localparam int M_ENTER = 1;
   localparam int M_OFF   = 2;
   localparam int M_EXIT  = 3;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   logic tm   = 1'b0;

   always #5 clk = ~clk;

   cluster_multi_clock_gate_if #(.NB_DOMAINS(ND), .NB_BUSY(NB), .IDLE_CNT_W(CW)) ifa ();
   cluster_multi_clock_gate_if #(.NB_DOMAINS(ND), .NB_BUSY(NB), .IDLE_CNT_W(CW)) ifb ();

   cluster_multi_clock_gate #(.NB_DOMAINS(ND), .NB_BUSY(NB), .IDLE_CNT_W(CW),
                              .ISO_CYCLES(ISO), .SYNC_EVENTS(0)) u_dut_a (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .test_mode_i (tm),
      .cg_if       (ifa)
   );

   cluster_multi_clock_gate #(.NB_DOMAINS(ND), .NB_BUSY(NB), .IDLE_CNT_W(CW),
                              .ISO_CYCLES(ISO), .SYNC_EVENTS(1)) u_dut_b (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .test_mode_i (tm),
      .cg_if       (ifb)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model of domain behaviour for instance A.
   int   m_mode [ND];
   int   m_idle [ND];
   int   m_left [ND];
   bit   m_post;
   logic [ND-1:0] e_iso, e_gat, e_clk;

   typedef struct {
      int          n;
      logic [1:0]  req;
      logic [1:0]  ev;
      logic [7:0]  busy;
      logic        tmv;
      logic [1:0]  iso;
      logic [1:0]  gat;
      logic [1:0]  clk;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string nm, input logic [ND-1:0] act, input logic [ND-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      int  thr;
      bit  wake;
      for (int d = 0; d < ND; d++) e_clk[d] = (rstn && m_mode[d] != M_OFF) || tm;
      if (!rstn) begin
         for (int d = 0; d < ND; d++) begin
            m_mode[d] = M_RUN;
            m_idle[d] = 0;
            m_left[d] = 0;
         end
         m_post = 0;
      end else begin
         thr = (ifa.idle_thr_i == 0) ? 1 : int'(ifa.idle_thr_i);
         for (int d = 0; d < ND; d++) begin
            wake = (ifa.busy_i[d*NB +: NB] != 0) || ifa.incoming_req_i[d]
                   || ifa.events_i[d] || !ifa.cg_en_i[d];
            case (m_mode[d])
               M_RUN: begin
                  if (wake) m_idle[d] = 0;
                  else begin
                     m_idle[d]++;
                     if (m_idle[d] >= thr) begin
                        m_mode[d] = M_ENTER;
                        m_left[d] = ISO;
                     end
                  end
               end
               M_ENTER: begin
                  if (wake) begin
                     m_mode[d] = M_EXIT;
                     m_left[d] = ISO;
                  end else begin
                     m_left[d]--;
                     if (m_left[d] == 0) m_mode[d] = M_OFF;
                  end
               end
               M_OFF: begin
                  if (wake) begin
                     m_mode[d] = M_EXIT;
                     m_left[d] = ISO;
                  end
               end
               default: begin
                  m_left[d]--;
                  if (m_left[d] == 0) begin
                     m_mode[d] = M_RUN;
                     m_idle[d] = 0;
                  end
               end
            endcase
         end
         m_post = 1;
      end
      for (int d = 0; d < ND; d++) begin
         e_iso[d] = (m_mode[d] != M_RUN) || !m_post;
         e_gat[d] = (m_mode[d] == M_OFF);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("model_iso", ifa.isolate_o, e_iso);
      check("model_gated", ifa.gated_o, e_gat);
      check("model_clk", ifa.domain_clk_o, e_clk);
   endtask

   function automatic void add(input int n, input logic [1:0] req, input logic [1:0] ev,
                               input logic [7:0] busy, input logic tmv,
                               input logic [1:0] iso, input logic [1:0] gat, input logic [1:0] ck);
      vec_t v;
      v.n = n; v.req = req; v.ev = ev; v.busy = busy; v.tmv = tmv;
      v.iso = iso; v.gat = gat; v.clk = ck;
      tbl.push_back(v);
   endfunction

   initial begin
      ifa.cg_en_i = 2'b11; ifa.idle_thr_i = 4'd4; ifa.busy_i = '0;
      ifa.events_i = '0;   ifa.incoming_req_i = '0;
      ifb.cg_en_i = 2'b11; ifb.idle_thr_i = 4'd4; ifb.busy_i = '0;
      ifb.events_i = '0;   ifb.incoming_req_i = '0;

      // Reset release, gating of both domains, request wake of domain 0.
      add(3, 2'b00, 2'b00, 8'h00, 1'b0, 2'b00, 2'b00, 2'b11);
      add(2, 2'b00, 2'b00, 8'h00, 1'b0, 2'b11, 2'b00, 2'b11);
      add(1, 2'b00, 2'b00, 8'h00, 1'b0, 2'b11, 2'b11, 2'b11);
      add(2, 2'b00, 2'b00, 8'h00, 1'b0, 2'b11, 2'b11, 2'b00);
      add(1, 2'b01, 2'b00, 8'h00, 1'b0, 2'b11, 2'b10, 2'b00);
      add(1, 2'b00, 2'b00, 8'h00, 1'b0, 2'b11, 2'b10, 2'b01);
      add(1, 2'b00, 2'b00, 8'h00, 1'b0, 2'b10, 2'b10, 2'b01);
      // Busy every third cycle: domain 0 never reaches the threshold.
      for (int k = 0; k < 4; k++) begin
         add(1, 2'b00, 2'b00, 8'h01, 1'b0, 2'b10, 2'b10, 2'b01);
         add(2, 2'b00, 2'b00, 8'h00, 1'b0, 2'b10, 2'b10, 2'b01);
      end
      add(1, 2'b00, 2'b00, 8'h01, 1'b0, 2'b10, 2'b10, 2'b01);
      // Event on the second ISO_IN cycle aborts gating.
      add(3, 2'b00, 2'b00, 8'h00, 1'b0, 2'b10, 2'b10, 2'b01);
      add(2, 2'b00, 2'b00, 8'h00, 1'b0, 2'b11, 2'b10, 2'b01);
      add(1, 2'b00, 2'b01, 8'h00, 1'b0, 2'b11, 2'b10, 2'b01);
      add(1, 2'b00, 2'b00, 8'h00, 1'b0, 2'b11, 2'b10, 2'b01);
      add(1, 2'b00, 2'b00, 8'h00, 1'b0, 2'b10, 2'b10, 2'b01);
      // Test mode: clocks keep running while the FSM still gates.
      add(3, 2'b00, 2'b00, 8'h00, 1'b1, 2'b10, 2'b10, 2'b11);
      add(2, 2'b00, 2'b00, 8'h00, 1'b1, 2'b11, 2'b10, 2'b11);
      add(3, 2'b00, 2'b00, 8'h00, 1'b1, 2'b11, 2'b11, 2'b11);

      repeat (3) step();
      check("rst_iso", ifa.isolate_o, 2'b11);
      check("rst_gated", ifa.gated_o, 2'b00);
      check("rst_clk", ifa.domain_clk_o, 2'b00);
      rstn = 1'b1;
      #1;
      check("rel_iso_hold", ifa.isolate_o, 2'b11);

      foreach (tbl[i]) begin
         for (int c = 0; c < tbl[i].n; c++) begin
            ifa.incoming_req_i = tbl[i].req;
            ifa.events_i       = tbl[i].ev;
            ifa.busy_i         = tbl[i].busy;
            tm                 = tbl[i].tmv;
            step();
            check($sformatf("tbl%0d_iso", i), ifa.isolate_o, tbl[i].iso);
            check($sformatf("tbl%0d_gated", i), ifa.gated_o, tbl[i].gat);
            check($sformatf("tbl%0d_clk", i), ifa.domain_clk_o, tbl[i].clk);
         end
      end
      ifa.incoming_req_i = '0; ifa.events_i = '0; ifa.busy_i = '0;
      tm = 1'b0;
      repeat (2) step();

      // Synchronised event: clock returns three cycles after the pulse.
      check("sync_pre_gated", ifb.gated_o, 2'b11);
      ifb.events_i = 2'b01;
      step();
      ifb.events_i = 2'b00;
      check("sync_e1_gated", ifb.gated_o, 2'b11);
      step();
      check("sync_e2_gated", ifb.gated_o, 2'b11);
      check("sync_e2_clk", ifb.domain_clk_o, 2'b00);
      step();
      check("sync_e3_gated", ifb.gated_o, 2'b10);
      check("sync_e3_clk", ifb.domain_clk_o, 2'b00);
      check("sync_e3_iso", ifb.isolate_o, 2'b11);
      step();
      check("sync_e4_clk", ifb.domain_clk_o, 2'b01);

      // Asynchronous reset while gated.
      check("pre_rst_gated", ifa.gated_o, 2'b11);
      #2;
      rstn = 1'b0;
      #1;
      check("async_rst_gated", ifa.gated_o, 2'b00);
      check("async_rst_iso", ifa.isolate_o, 2'b11);
      repeat (2) step();
      rstn = 1'b1;

      for (int c = 0; c < 1500; c++) begin
         ifa.cg_en_i = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
         for (int d = 0; d < ND; d++) begin
            ifa.busy_i[d*NB +: NB]  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            ifa.incoming_req_i[d]   = ($urandom_range(0, 11) == 0);
            ifa.events_i[d]         = ($urandom_range(0, 11) == 0);
         end
         if ($urandom_range(0, 39) == 0) ifa.idle_thr_i = 4'($urandom_range(0, 6));
         if ($urandom_range(0, 49) == 0) tm = ~tm;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/cluster_multi_clock_gate.md
Name: cluster_multi_clock_gate

Overview:
- Next-generation cluster clock-gating controller.
- Manages NB_DOMAINS independently gated clock domains (e.g. core groups, HWPE, DMA) from one free-running cluster clock.
- Each domain has a per-domain FSM with a programmable idle threshold, isolation lead/lag windows around gating, optional event synchronisation and per-domain status.
- Sits between the cluster control unit / event unit and the clkgating cells feeding each domain.

Parameters:
- NB_DOMAINS, 2, number of independently gated domains (1..16).
- NB_BUSY, 4, busy request lines per domain.
- IDLE_CNT_W, 4, width of idle counter and idle_thr_i.
- ISO_CYCLES, 2, isolation lead and lag cycles (1..7).
- SYNC_EVENTS, 0, 1 = events_i through a 2-flop synchroniser before use.

Ports:
- clk_i  in  1  free-running cluster clock.
- rstn_i  in  1  asynchronous active-low reset.
- test_mode_i  in  1  forces all gated clocks on through the clkgating cells.
- cg_en_i  in  NB_DOMAINS  per-domain gating permission.
- idle_thr_i  in  IDLE_CNT_W  consecutive idle cycles required before gating; 0 is treated as 1.
- busy_i  in  NB_DOMAINS*NB_BUSY  busy lines; domain d uses bits [d*NB_BUSY +: NB_BUSY].
- events_i  in  NB_DOMAINS  per-domain wake events.
- incoming_req_i  in  NB_DOMAINS  per-domain incoming interconnect request.
- isolate_o  out  NB_DOMAINS  isolation request for domain d.
- gated_o  out  NB_DOMAINS  1 while domain d is in GATED.
- domain_clk_o  out  NB_DOMAINS  gated clock of domain d, one clkgating instance per domain.

Behaviour:
- Reset (rstn_i=0):
  - All FSMs go to RUN; idle/iso counters 0; event sync flops 0; gated_o=0.
  - isolate_o=all 1s.
  - Clock enable = 0, because every enable is ANDed with rstn_i.
- Post-reset isolation:
  - A shared delayed-reset flop (reset 0, set to 1 on the first clk_i edge after reset release) holds isolate_o=1 until that edge.
  - isolate_o[d] = FSM isolate | ~delayed-reset flop.
- Per-domain terms:
  - ev[d] = events_i[d], or its 2-flop synchronised copy when SYNC_EVENTS=1.
  - wake[d] = |busy[d] | incoming_req_i[d] | ev[d] | ~cg_en_i[d].
  - idle[d] = ~wake[d].
- FSM states, per domain (enable = clock enable):
  - RUN: enable=1, isolate=0. idle_cnt increments while idle and clears on any wake cycle. It saturates at threshold. When idle has been true for thr consecutive cycles (thr = max(idle_thr_i,1)), go to ISO_IN on the next edge with iso_cnt=0.
  - ISO_IN: enable=1, isolate=1. If wake, go to ISO_OUT (iso_cnt=0). Else iso_cnt++; after ISO_CYCLES cycles in ISO_IN, go to GATED.
  - GATED: enable=0, isolate=1, gated_o=1. If wake, go to ISO_OUT with iso_cnt=0.
  - ISO_OUT: enable=1, isolate=1. Stay ISO_CYCLES cycles regardless of further idle, then go to RUN with idle_cnt=0.
- Priority: wake beats idle in every state. idle_thr_i is sampled combinationally each cycle; changing it mid-count compares the running count against the new value.
- Latency:
  - Idle onset to gated clock off = thr + ISO_CYCLES cycles.
  - Wake to clock on = 1 cycle, plus 2 when SYNC_EVENTS=1 and the wake source is an event.
  - Wake to isolate_o low = 1 + ISO_CYCLES cycles.
- Clock gating:
  - Each domain_clk_o[d] comes from one clkgating cell: i_clk=clk_i, i_test_mode=test_mode_i, i_enable=enable[d] & rstn_i.
  - test_mode_i=1 keeps clocks running; FSMs and isolate_o keep operating normally.
- Domains are fully independent and share only clk_i, rstn_i, test_mode_i, idle_thr_i and the delayed-reset flop.
- Reset asserted in any state returns to reset values immediately (asynchronously), including from GATED.
- Counters never wrap: idle_cnt saturates; iso_cnt is sized to hold ISO_CYCLES.

Test Plan:
- Reset release, all inputs idle, cg_en_i=2'b11, idle_thr_i=4, ISO_CYCLES=2:
  - isolate_o=2'b11 through the first edge after release, then 0.
  - isolate_o rises after 4 idle cycles.
  - domain clocks stop 2 cycles later; gated_o=2'b11.
- Domain 0 GATED, pulse incoming_req_i[0] for 1 cycle:
  - domain_clk_o[0] resumes the next cycle.
  - isolate_o[0] falls 3 cycles after the request.
  - domain 1 stays gated.
- busy toggles every 3rd cycle with idle_thr_i=4:
  - no gating ever.
  - idle_cnt cleared each busy cycle.
- Wake during ISO_IN (event on 2nd ISO_IN cycle):
  - FSM goes to ISO_OUT, clock never stops.
  - isolate_o low after 2 more cycles.
- SYNC_EVENTS=1, domain gated, events_i pulse:
  - clock re-enabled 3 cycles after the pulse.
- test_mode_i=1 with domain idle:
  - domain_clk_o keeps toggling while isolate_o and gated_o follow the FSM.
  - Assert rstn_i mid-GATED: gated_o=0 and isolate_o=1 immediately.
